// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into a UART transmitter through a start-pulse handshake
// Define UART_TX_FIFO_CRLF_EN to send 0x0D ahead of every queued 0x0A.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  flush,
   input  logic                  tx_ready,
   output logic                  tx_en,
   output logic [7:0]            tx_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);
   localparam int                    DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  pop;
   logic                  push;
   logic                  lf_issue;
   logic [7:0]            head_byte;
   logic [7:0]            issue_byte;

   assign full      = (level == LEVEL_FULL);
   assign empty     = (level == '0);
   assign head_byte = mem[rd_ptr];
   assign pop       = (state == IDLE) && tx_ready && !empty && !flush && !lf_issue;
   // A pop in the same cycle frees a slot, so a push into a full buffer is still taken.
   assign push      = wr_en && !flush && (!full || pop);

`ifdef UART_TX_FIFO_CRLF_EN
   logic lf_pending;

   assign lf_issue   = (state == IDLE) && tx_ready && lf_pending;
   assign issue_byte = lf_issue ? 8'h0A : ((head_byte == 8'h0A) ? 8'h0D : head_byte);

   // The LF was already popped with its CR; it goes out later without touching the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lf_pending <= 1'b0;
      end else if (lf_issue) begin
         lf_pending <= 1'b0;
      end else if (pop && head_byte == 8'h0A) begin
         lf_pending <= 1'b1;
      end
   end
`else
   assign lf_issue   = 1'b0;
   assign issue_byte = head_byte;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            level <= level + LEVEL_ONE;
         end else if (pop && !push) begin
            level <= level - LEVEL_ONE;
         end
         if (wr_en && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // A new byte is only issued after the transmitter has dropped and re-raised tx_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_en   <= 1'b0;
         tx_data <= 8'h00;
      end else begin
         tx_en <= 1'b0;
         case (state)
            IDLE: begin
               if (pop || lf_issue) begin
                  state   <= SEND;
                  tx_en   <= 1'b1;
                  tx_data <= issue_byte;
               end
            end
            SEND: begin
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (!tx_ready) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (tx_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4; FIFO depth SHALL be 2**DEPTH_LOG2 bytes.
REQ-002 clk  input  1  system clock, all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_en  input  1  push request for wr_data this cycle.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 flush  input  1  synchronous clear of queued bytes.
REQ-007 tx_ready  input  1  transmitter idle/ready flag from the UART transmitter.
REQ-008 tx_en  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte presented with tx_en, held stable until the next tx_en.
REQ-010 full  output  1  level equals depth.
REQ-011 empty  output  1  level equals zero.
REQ-012 level  output  DEPTH_LOG2+1  number of queued bytes, excluding the byte in flight.
REQ-013 overflow  output  1  sticky flag, set when a push is dropped.

Function
REQ-014 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo depth.
REQ-015 Push while not full SHALL store wr_data at the write pointer and advance it; level +1 the next cycle.
REQ-016 Push while full SHALL be dropped, contents unchanged, overflow set to 1 until reset.
REQ-017 Push and pop in the same cycle SHALL both take effect; level unchanged; when full, a simultaneous pop frees the slot and the push SHALL be accepted.
REQ-018 Drain FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> SEND when not empty and tx_ready=1; the byte at the read pointer SHALL be popped in that cycle and registered into tx_data.
REQ-020 SEND SHALL assert tx_en for exactly one cycle, then -> WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE when tx_ready=0; WAIT_DONE -> IDLE when tx_ready=1.
REQ-022 tx_en SHALL never be asserted outside SEND; no second byte SHALL be issued before the transmitter has dropped and reraised tx_ready.
REQ-023 Minimum issue-to-issue spacing SHALL be 4 cycles; a continuous backlog SHALL be sent with no gaps beyond the FSM overhead.
REQ-024 flush SHALL reset both pointers and level to 0 next cycle; a byte already in SEND/WAIT states SHALL complete normally.
REQ-025 flush and wr_en in the same cycle: flush wins, the byte is discarded, overflow unaffected.
REQ-026 full/empty SHALL be derived from registered state, valid the cycle after the changing event.

Reset
REQ-027 On rst_n=0, immediately and asynchronously: pointers=0, level=0, FSM=IDLE, tx_en=0, tx_data=0x00, overflow=0, empty=1, full=0.
REQ-028 Reset mid-transfer SHALL abandon the in-flight byte; the buffer RAM contents need not be cleared.
REQ-029 First pop after reset deassertion SHALL be no earlier than the second clk edge.

Configuration
REQ-030 Macro UART_TX_FIFO_CRLF_EN: when defined, popping 0x0A SHALL first issue 0x0D, then 0x0A as a separate full SEND/WAIT cycle without popping again; level counts the LF as one byte.
REQ-031 Without UART_TX_FIFO_CRLF_EN, all bytes SHALL be sent verbatim, one transmission per pop.

Verification (DEPTH_LOG2=4, transmitter model: tx_ready low 3 cycles after tx_en)
REQ-032 Push 0x41,0x42,0x43 back-to-back, tx_ready=1 -> tx_en pulses carry 0x41,0x42,0x43 in order; empty=1 after the third pop.
REQ-033 Hold tx_ready=0, push 17 bytes 0x00..0x10 -> full=1 after the 16th push, byte 0x10 dropped, overflow=1, level=16.
REQ-034 Full FIFO, tx_ready raised, push 0x55 in the pop cycle -> push accepted, level stays 16, 0x55 transmitted last.
REQ-035 Queue 5 bytes, assert flush while the first is in WAIT_BUSY -> first byte completes, no further tx_en, level=0, empty=1.
REQ-036 Assert rst_n=0 during WAIT_DONE with 3 bytes queued -> tx_en=0, level=0, FSM in IDLE immediately; no tx_en after release with no new pushes.
REQ-037 With UART_TX_FIFO_CRLF_EN, push 0x48,0x0A -> tx_en sequence 0x48,0x0D,0x0A; without it -> 0x48,0x0A.
